// File: rtl/aes_ctrl_pkg.sv
// Shared constants and state encoding for the AES controller's serial-read stage.
package aes_ctrl_pkg;

    localparam int unsigned BLOCK_BYTES = 16;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned BLOCK_W     = BLOCK_BYTES * BYTE_W;
    localparam int unsigned CNT_W       = 5;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StDone    = 2'd2
    } collector_state_e;

endpackage

// File: rtl/serial_block_collector_if.sv
// Controller/UART-side bundle of the serial block collector.
// TimeoutErr exists only when SERIAL_COLLECT_TIMEOUT_EN is defined.
interface serial_block_collector_if;
    import aes_ctrl_pkg::*;

    logic               En;
    logic               Ry;
    logic [BYTE_W-1:0]  RxData;
    logic               RxValid;
    logic [BLOCK_W-1:0] Block;
    logic               BlockValid;
    logic [CNT_W-1:0]   ByteCount;
    logic               DropPulse;
`ifdef SERIAL_COLLECT_TIMEOUT_EN
    logic               TimeoutErr;

    modport master (
        output En, RxData, RxValid,
        input  Ry, Block, BlockValid, ByteCount, DropPulse, TimeoutErr
    );
    modport slave (
        input  En, RxData, RxValid,
        output Ry, Block, BlockValid, ByteCount, DropPulse, TimeoutErr
    );
`else
    modport master (
        output En, RxData, RxValid,
        input  Ry, Block, BlockValid, ByteCount, DropPulse
    );
    modport slave (
        input  En, RxData, RxValid,
        output Ry, Block, BlockValid, ByteCount, DropPulse
    );
`endif

endinterface

// File: rtl/byte_gap_timer.sv
// Resettable up-counter that flags the cycle in which Limit idle clocks have elapsed.
module byte_gap_timer #(
    parameter int unsigned Limit = 1000
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int unsigned CntW = $clog2(Limit + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            at_limit;

    assign at_limit = (cnt_q == CntW'(Limit - 1));
    assign expire_o = en_i & at_limit;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_limit ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_block_collector.sv
// Collects BLOCK_BYTES UART bytes into one AES block under the controller's En/Ry handshake.
// Optional inter-byte timeout enabled by defining SERIAL_COLLECT_TIMEOUT_EN.
module serial_block_collector
    import aes_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input logic                     Clk,
    input logic                     Rst,
    serial_block_collector_if.slave bus
);
    collector_state_e   state_q, state_d;
    logic [BLOCK_W-1:0] block_q, block_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   count_base;
    logic               ry_q, ry_d;
    logic               bvalid_q, bvalid_d;
    logic               drop_q, drop_d;
    logic               tout_q, tout_d;
    logic               accept;
    logic               gap_expire;

    assign accept = bus.En & bus.RxValid & ((state_q == StIdle) | (state_q == StCollect));
    // Entering from IDLE restarts the count, so the first byte is byte 0.
    assign count_base = (state_q == StIdle) ? '0 : count_q;

`ifdef SERIAL_COLLECT_TIMEOUT_EN
    logic gap_active;

    assign gap_active = (state_q == StCollect) && (count_q != '0);

    byte_gap_timer #(
        .Limit (TIMEOUT_CYCLES)
    ) u_gap_timer (
        .Clk      (Clk),
        .Rst      (Rst),
        .clr_i    (accept | ~gap_active),
        .en_i     (gap_active),
        .expire_o (gap_expire)
    );

    assign bus.TimeoutErr = tout_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign gap_expire         = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        block_d  = block_q;
        count_d  = count_q;
        ry_d     = 1'b0;
        bvalid_d = bvalid_q;
        drop_d   = 1'b0;
        tout_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.En) begin
                    state_d  = StCollect;
                    count_d  = '0;
                    bvalid_d = 1'b0;
                end else if (bus.RxValid) begin
                    drop_d = 1'b1;
                end
            end
            StCollect: begin
                if (!bus.En) begin
                    state_d  = StIdle;
                    count_d  = '0;
                    bvalid_d = 1'b0;
                    drop_d   = bus.RxValid;
                end else if (!bus.RxValid && gap_expire) begin
                    count_d = '0;
                    tout_d  = 1'b1;
                end
            end
            StDone: begin
                if (!bus.En) begin
                    state_d = StIdle;
                end
                drop_d = bus.RxValid;
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            block_d = {block_q[BLOCK_W-BYTE_W-1:0], bus.RxData};
            count_d = count_base + 1'b1;
            if (count_base == CNT_W'(BLOCK_BYTES - 1)) begin
                state_d  = StDone;
                ry_d     = 1'b1;
                bvalid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= StIdle;
            block_q  <= '0;
            count_q  <= '0;
            ry_q     <= 1'b0;
            bvalid_q <= 1'b0;
            drop_q   <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            block_q  <= block_d;
            count_q  <= count_d;
            ry_q     <= ry_d;
            bvalid_q <= bvalid_d;
            drop_q   <= drop_d;
            tout_q   <= tout_d;
        end
    end

    assign bus.Ry         = ry_q;
    assign bus.Block      = block_q;
    assign bus.BlockValid = bvalid_q;
    assign bus.ByteCount  = count_q;
    assign bus.DropPulse  = drop_q;

endmodule

// File: tb/tb_serial_block_collector.sv
// Directed self-checking bench for serial_block_collector (honours SERIAL_COLLECT_TIMEOUT_EN).
module tb_serial_block_collector;
    import aes_ctrl_pkg::*;

    logic Clk;
    logic Rst;
    int   n_checks;
    int   n_pass;
    int   ry_count;
    int   ry_before;

    serial_block_collector_if bus ();

    serial_block_collector #(
        .TIMEOUT_CYCLES (100)
    ) u_dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (bus.Ry === 1'b1) ry_count++;
    end

    // Tasks start and end just after a falling edge.
    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.RxValid = 1'b1;
        bus.RxData  = b;
        @(negedge Clk);
        bus.RxValid = 1'b0;
    endtask

    task automatic test_reset();
        Rst         = 1'b1;
        bus.En      = 1'b0;
        bus.RxValid = 1'b0;
        bus.RxData  = 8'h00;
        idle(2);
        n_checks++;
        if ({bus.Ry, bus.BlockValid, bus.DropPulse} !== 3'b000 || bus.ByteCount !== 5'd0
            || bus.Block !== 128'h0) begin
            $display("FAIL reset_outputs: got ry/bv/drop=%b cnt=%0d block=%h want all zero",
                     {bus.Ry, bus.BlockValid, bus.DropPulse}, bus.ByteCount, bus.Block);
        end else n_pass++;
        Rst = 1'b0;
        idle(1);
        send_byte(8'h77);
        n_checks++;
        if (bus.DropPulse !== 1'b1 || bus.ByteCount !== 5'd0) begin
            $display("FAIL idle_drop: got drop=%b cnt=%0d want drop=1 cnt=0",
                     bus.DropPulse, bus.ByteCount);
        end else n_pass++;
    endtask

    task automatic test_full_block();
        bus.En = 1'b1;
        idle(1);
        ry_before = ry_count;
        for (int i = 0; i < 15; i++) begin
            send_byte(8'(i));
            idle(3);
        end
        n_checks++;
        if (bus.ByteCount !== 5'd15 || bus.Ry !== 1'b0 || ry_count != ry_before) begin
            $display("FAIL partial_count: got cnt=%0d ry=%b pulses=%0d want cnt=15 ry=0 pulses=0",
                     bus.ByteCount, bus.Ry, ry_count - ry_before);
        end else n_pass++;
        send_byte(8'h0F);
        n_checks++;
        if (bus.Ry !== 1'b1 || bus.BlockValid !== 1'b1 || bus.ByteCount !== 5'd16) begin
            $display("FAIL ry_latency: got ry=%b bv=%b cnt=%0d want ry=1 bv=1 cnt=16",
                     bus.Ry, bus.BlockValid, bus.ByteCount);
        end else n_pass++;
        n_checks++;
        if (bus.Block !== 128'h000102030405060708090A0B0C0D0E0F) begin
            $display("FAIL block_incr: got %h want 000102030405060708090a0b0c0d0e0f", bus.Block);
        end else n_pass++;
        idle(1);
        n_checks++;
        if (bus.Ry !== 1'b0 || ry_count - ry_before != 1) begin
            $display("FAIL ry_width: got ry=%b pulses=%0d want ry=0 pulses=1",
                     bus.Ry, ry_count - ry_before);
        end else n_pass++;
    endtask

    task automatic test_done_drop();
        ry_before = ry_count;
        send_byte(8'hAA);
        n_checks++;
        if (bus.DropPulse !== 1'b1 || bus.Block !== 128'h000102030405060708090A0B0C0D0E0F
            || bus.ByteCount !== 5'd16) begin
            $display("FAIL done_drop: got drop=%b cnt=%0d block=%h want drop=1 cnt=16 frozen",
                     bus.DropPulse, bus.ByteCount, bus.Block);
        end else n_pass++;
        bus.En = 1'b0;
        idle(2);
        n_checks++;
        if (bus.BlockValid !== 1'b1 || bus.DropPulse !== 1'b0 || ry_count != ry_before
            || bus.Block !== 128'h000102030405060708090A0B0C0D0E0F) begin
            $display("FAIL done_exit: got bv=%b drop=%b pulses=%0d want bv=1 drop=0 pulses=0",
                     bus.BlockValid, bus.DropPulse, ry_count - ry_before);
        end else n_pass++;
    endtask

    task automatic test_abort();
        bus.En = 1'b1;
        idle(1);
        n_checks++;
        if (bus.BlockValid !== 1'b0 || bus.ByteCount !== 5'd0) begin
            $display("FAIL start_clear: got bv=%b cnt=%0d want bv=0 cnt=0",
                     bus.BlockValid, bus.ByteCount);
        end else n_pass++;
        ry_before = ry_count;
        for (int i = 0; i < 5; i++) begin
            send_byte(8'h40 + 8'(i));
            idle(1);
        end
        n_checks++;
        if (bus.ByteCount !== 5'd5) begin
            $display("FAIL abort_pre: got cnt=%0d want 5", bus.ByteCount);
        end else n_pass++;
        // Byte coincident with En falling must not be accepted.
        bus.En = 1'b0;
        send_byte(8'h99);
        n_checks++;
        if (bus.ByteCount !== 5'd0 || bus.BlockValid !== 1'b0 || bus.DropPulse !== 1'b1
            || ry_count != ry_before) begin
            $display("FAIL abort: got cnt=%0d bv=%b drop=%b pulses=%0d want 0/0/1/0",
                     bus.ByteCount, bus.BlockValid, bus.DropPulse, ry_count - ry_before);
        end else n_pass++;
        bus.En = 1'b1;
        idle(1);
        for (int i = 0; i < 16; i++) send_byte(8'hFF - 8'(i));
        idle(1);
        n_checks++;
        if (bus.Block !== 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0 || ry_count - ry_before != 1) begin
            $display("FAIL block_decr: got %h pulses=%0d want fffefd..f0 pulses=1",
                     bus.Block, ry_count - ry_before);
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        bus.En = 1'b0;
        idle(1);
        bus.En = 1'b1;
        idle(1);
        n_checks++;
        if (bus.BlockValid !== 1'b0 || bus.ByteCount !== 5'd0) begin
            $display("FAIL back_to_back: got bv=%b cnt=%0d want bv=0 cnt=0",
                     bus.BlockValid, bus.ByteCount);
        end else n_pass++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 8; i++) send_byte(8'h80 + 8'(i));
        n_checks++;
        if (bus.ByteCount !== 5'd8) begin
            $display("FAIL pre_reset_count: got %0d want 8", bus.ByteCount);
        end else n_pass++;
        #2 Rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.Ry, bus.BlockValid, bus.DropPulse} !== 3'b000 || bus.ByteCount !== 5'd0
            || bus.Block !== 128'h0) begin
            $display("FAIL async_reset: got ry/bv/drop=%b cnt=%0d block=%h want all zero",
                     {bus.Ry, bus.BlockValid, bus.DropPulse}, bus.ByteCount, bus.Block);
        end else n_pass++;
        @(negedge Clk);
        Rst = 1'b0;
        idle(1);
        ry_before = ry_count;
        for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i));
        idle(1);
        n_checks++;
        if (bus.Block !== 128'h101112131415161718191A1B1C1D1E1F || ry_count - ry_before != 1
            || bus.BlockValid !== 1'b1) begin
            $display("FAIL post_reset_block: got %h pulses=%0d bv=%b want 1011..1f pulses=1 bv=1",
                     bus.Block, ry_count - ry_before, bus.BlockValid);
        end else n_pass++;
    endtask

    task automatic test_start_with_byte();
        bus.En = 1'b0;
        idle(1);
        ry_before   = ry_count;
        bus.En      = 1'b1;
        send_byte(8'h5A);
        n_checks++;
        if (bus.ByteCount !== 5'd1 || bus.BlockValid !== 1'b0) begin
            $display("FAIL start_byte: got cnt=%0d bv=%b want cnt=1 bv=0",
                     bus.ByteCount, bus.BlockValid);
        end else n_pass++;
        for (int i = 1; i < 16; i++) send_byte(8'(i));
        n_checks++;
        if (bus.Ry !== 1'b1 || bus.Block !== 128'h5A0102030405060708090A0B0C0D0E0F) begin
            $display("FAIL start_byte_block: got ry=%b block=%h want ry=1 5a0102..0f",
                     bus.Ry, bus.Block);
        end else n_pass++;
        idle(1);
    endtask

    task automatic test_timeout();
        bus.En = 1'b0;
        idle(1);
        bus.En = 1'b1;
        idle(1);
        ry_before = ry_count;
        for (int i = 0; i < 4; i++) send_byte(8'h21 + 8'(i));
`ifdef SERIAL_COLLECT_TIMEOUT_EN
        idle(99);
        n_checks++;
        if (bus.ByteCount !== 5'd4 || bus.TimeoutErr !== 1'b0) begin
            $display("FAIL timeout_early: got cnt=%0d terr=%b want cnt=4 terr=0",
                     bus.ByteCount, bus.TimeoutErr);
        end else n_pass++;
        idle(1);
        n_checks++;
        if (bus.ByteCount !== 5'd0 || bus.TimeoutErr !== 1'b1) begin
            $display("FAIL timeout_fire: got cnt=%0d terr=%b want cnt=0 terr=1",
                     bus.ByteCount, bus.TimeoutErr);
        end else n_pass++;
        idle(1);
        n_checks++;
        if (bus.TimeoutErr !== 1'b0) begin
            $display("FAIL timeout_width: got terr=%b want 0", bus.TimeoutErr);
        end else n_pass++;
        for (int i = 0; i < 16; i++) send_byte(8'h30 + 8'(i));
        idle(1);
        n_checks++;
        if (bus.Block !== 128'h303132333435363738393A3B3C3D3E3F || ry_count - ry_before != 1) begin
            $display("FAIL timeout_resync: got %h pulses=%0d want 3031..3f pulses=1",
                     bus.Block, ry_count - ry_before);
        end else n_pass++;
`else
        idle(1000);
        n_checks++;
        if (bus.ByteCount !== 5'd4) begin
            $display("FAIL long_gap: got cnt=%0d want 4", bus.ByteCount);
        end else n_pass++;
        for (int i = 0; i < 12; i++) send_byte(8'h25 + 8'(i));
        idle(1);
        n_checks++;
        if (bus.Block !== 128'h2122232425262728292A2B2C2D2E2F30 || ry_count - ry_before != 1) begin
            $display("FAIL long_gap_block: got %h pulses=%0d want 2122..30 pulses=1",
                     bus.Block, ry_count - ry_before);
        end else n_pass++;
`endif
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        ry_count = 0;
        test_reset();
        test_full_block();
        test_done_drop();
        test_abort();
        test_back_to_back();
        test_async_reset();
        test_start_with_byte();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
